// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared FSM states, EXE command codes and status bit positions for the multiply sequencer.
package mul_sequencer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ITER = 2'd1;
  localparam state_t ST_ACC  = 2'd2;
  localparam state_t ST_DONE = 2'd3;
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam int STAT_Z = 3;
  localparam int STAT_C = 2;
  localparam int STAT_N = 1;
  localparam int STAT_V = 0;
  function automatic logic [3:0] nz_flags(input logic [31:0] v);
    logic [3:0] f;
    f = '0;
    f[STAT_Z] = (v == '0);
    f[STAT_N] = v[31];
    return f;
  endfunction
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add MUL controller driving the external EXE-stage ALU; MLA (accumulate/acc ports, ACC state) only when MUL_ACC_EN is defined.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             set_flags,
`ifdef MUL_ACC_EN
  input  logic             accumulate,
  input  logic [WIDTH-1:0] acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status,
  output logic             flags_we,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_cmd,
  output logic             alu_c,
  input  logic [WIDTH-1:0] alu_result
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d, mplier_q, mplier_d, result_q, result_d;
  logic [3:0]       status_q, status_d;
  logic             sf_q, sf_d, go_acc, last;
`ifdef MUL_ACC_EN
  logic             acc_en_q, acc_en_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  assign busy     = (state_q == ST_ITER) || (state_q == ST_ACC);
  assign done     = (state_q == ST_DONE);
  assign flags_we = done & sf_q;
  assign result   = result_q;
  assign status   = status_q;
  assign alu_c    = 1'b0;
  assign last     = (mplier_q[WIDTH-1:1] == '0);

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sf_d     = sf_q;
    result_d = result_q;
    status_d = status_q;
`ifdef MUL_ACC_EN
    acc_en_d = acc_en_q;
    acc_d    = acc_q;
    go_acc   = acc_en_q;
`else
    go_acc   = 1'b0;
`endif
    alu_cmd  = busy ? EXE_ADD : EXE_NOP;
    alu_in1  = busy ? prod_q : '0;
    alu_in2  = (state_q == ST_ITER && mplier_q[0]) ? mcand_q : '0;
`ifdef MUL_ACC_EN
    if (state_q == ST_ACC) alu_in2 = acc_q;
`endif
    if (!busy) begin
      state_d = start ? ST_ITER : ST_IDLE;
      if (start) begin
        prod_d   = '0;
        mcand_d  = op_a;
        mplier_d = op_b;
        sf_d     = set_flags;
`ifdef MUL_ACC_EN
        acc_en_d = accumulate;
        acc_d    = acc;
`endif
      end
    end else begin
      prod_d = alu_result;
      if (state_q == ST_ITER) begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      // the final product is latched here so result holds across later idle cycles
      if (state_q == ST_ACC || (last && !go_acc)) begin
        state_d  = ST_DONE;
        result_d = alu_result;
        status_d = nz_flags(alu_result);
      end else if (last) begin
        state_d = ST_ACC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sf_q     <= 1'b0;
      result_q <= '0;
      status_q <= '0;
`ifdef MUL_ACC_EN
      acc_en_q <= 1'b0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sf_q     <= sf_d;
      result_q <= result_d;
      status_q <= status_d;
`ifdef MUL_ACC_EN
      acc_en_q <= acc_en_d;
      acc_q    <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for mul_sequencer with a behavioural ALU and product model; honours MUL_ACC_EN.
module tb_mul_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, set_flags;
  logic [31:0] op_a, op_b;
`ifdef MUL_ACC_EN
  logic        accumulate;
  logic [31:0] acc;
`endif
  logic        busy, done, flags_we, alu_c;
  logic [31:0] result, alu_in1, alu_in2, alu_result;
  logic [3:0]  status, alu_cmd;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  st;
    logic        fwe;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign alu_result = (alu_cmd == 4'b0010) ? alu_in1 + alu_in2 : 32'h0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .set_flags(set_flags),
`ifdef MUL_ACC_EN
    .accumulate(accumulate), .acc(acc),
`endif
    .busy(busy), .done(done), .result(result), .status(status), .flags_we(flags_we),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd), .alu_c(alu_c), .alu_result(alu_result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("status", {28'h0, status}, {28'h0, e.st});
        chk("flags_we", {31'h0, flags_we}, {31'h0, e.fwe});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sf, input logic accum, input logic [31:0] addend);
    int   w = 0;
    int   k = 1;
    exp_t e;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("busy_timeout", 32'd1, 32'd0);
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    e.res = a * b;
`ifdef MUL_ACC_EN
    if (accum) e.res = e.res + addend;
    e.cyc = cyc + k + 1 + (accum ? 1 : 0);
`else
    e.cyc = cyc + k + 1;
`endif
    e.st  = {e.res == 32'h0, 1'b0, e.res[31], 1'b0};
    e.fwe = sf;
    q.push_back(e);
    op_a = a;
    op_b = b;
    set_flags = sf;
`ifdef MUL_ACC_EN
    accumulate = accum;
    acc = addend;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_flags = 1'b0;
    op_a = '0;
    op_b = '0;
`ifdef MUL_ACC_EN
    accumulate = 1'b0;
    acc = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_flags_we", {31'h0, flags_we}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_status", {28'h0, status}, 32'h0);
    chk("rst_alu_cmd", {28'h0, alu_cmd}, 32'h0);
    chk("rst_alu_in1", alu_in1, 32'h0);
    chk("rst_alu_in2", alu_in2, 32'h0);
    chk("alu_c", {31'h0, alu_c}, 32'h0);

    issue(32'd7, 32'd5, 1'b0, 1'b0, 32'h0);
    chk("busy_iter", {31'h0, busy}, 32'h1);
    chk("alu_cmd_add", {28'h0, alu_cmd}, 32'h2);
    drain();
    issue(32'h12345678, 32'h0, 1'b1, 1'b0, 32'h0);
    drain();
    issue(32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 32'h0);
    drain();
`ifdef MUL_ACC_EN
    issue(32'd3, 32'd4, 1'b0, 1'b1, 32'd10);
    drain();
`endif
    // start pulses while busy must not disturb the running op
    issue(32'hDEADBEEF, 32'h00F00001, 1'b1, 1'b0, 32'h0);
    start = 1'b1;
    op_a = 32'h11111111;
    op_b = 32'h3;
    repeat (4) @(negedge clk);
    start = 1'b0;
    drain();

    // back-to-back: each issue lands in the previous op's done cycle
    issue(32'd9, 32'd11, 1'b1, 1'b0, 32'h0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
    issue(32'h80000000, 32'd2, 1'b0, 1'b0, 32'h0);
    drain();

    // reset mid-operation drops the op with no done pulse
    issue(32'h5, 32'h80000001, 1'b0, 1'b0, 32'h0);
    repeat (9) @(negedge clk);
    q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (n % 7 == 0) a = 32'h0;
`ifdef MUL_ACC_EN
      issue(a, b, 1'($urandom), 1'($urandom), $urandom);
`else
      issue(a, b, 1'($urandom), 1'b0, 32'h0);
`endif
      if (n % 5 == 0) drain();
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
